// File: rtl/neuron_accumulator_if.sv
// Shared fixed-point defaults and the job/stream/result bundle of the neuron
// accumulator. The master drives jobs and pairs; the slave is the accumulator.
package definitions;
  localparam int Q_INT         = 8;
  localparam int Q_FRAC        = 8;
  localparam int ACT_MASK_SIZE = 4;
endpackage

interface neuron_accumulator_if #(
  parameter int Q_SIZE        = definitions::Q_INT + definitions::Q_FRAC,
  parameter int LEN_WIDTH     = 8,
  parameter int ACT_MASK_SIZE = definitions::ACT_MASK_SIZE
);
  // Job request, sampled when start is accepted
  logic                     start;
  logic [LEN_WIDTH-1:0]     len;
  logic [Q_SIZE-1:0]        bias;
  logic [ACT_MASK_SIZE-1:0] mask_in;
  logic                     bypass_in;
  logic                     busy;

  // Weight/input stream
  logic                     in_valid;
  logic                     in_ready;
  logic [Q_SIZE-1:0]        w;
  logic [Q_SIZE-1:0]        a;

  // Result towards the activation stage
  logic                     out_valid;
  logic                     out_ready;
  logic [Q_SIZE-1:0]        x;
  logic [ACT_MASK_SIZE-1:0] mask;
  logic                     act_bypass;

  modport master (
    output start, len, bias, mask_in, bypass_in, in_valid, w, a, out_ready,
    input  busy, in_ready, out_valid, x, mask, act_bypass
  );

  modport slave (
    input  start, len, bias, mask_in, bypass_in, in_valid, w, a, out_ready,
    output busy, in_ready, out_valid, x, mask, act_bypass
  );
endinterface

// File: rtl/neuron_accumulator.sv
// One-neuron fixed-point MAC: x = sat(floor((bias<<Q_FRAC + sum w*a) >> Q_FRAC)),
// delivered with the neuron's LUT mask and bypass flag over a valid/ready port.
module neuron_accumulator #(
  parameter  int Q_INT         = definitions::Q_INT,
  parameter  int Q_FRAC        = definitions::Q_FRAC,
  parameter  int ACT_MASK_SIZE = definitions::ACT_MASK_SIZE,
  parameter  int LEN_WIDTH     = 8,
  localparam int Q_SIZE        = Q_INT + Q_FRAC,
  localparam int ACC_W         = 2 * Q_SIZE + LEN_WIDTH
) (
  input logic                  clk,
  input logic                  rst_n,
  neuron_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, DONE} state_e;

  // Largest/smallest representable Q_INT.Q_FRAC values, widened to ACC_W
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - Q_SIZE + 1){1'b0}}, {(Q_SIZE - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
  logic [Q_SIZE-1:0]        x_q, x_d;
  logic [ACT_MASK_SIZE-1:0] mask_q, mask_d;
  logic                     bypass_q, bypass_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;

  logic signed [2*Q_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    shifted;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    mask_d      = mask_q;
    bypass_d    = bypass_q;
    out_valid_d = out_valid_q;

    prod     = $signed({{Q_SIZE{bus.w[Q_SIZE-1]}}, bus.w}) *
               $signed({{Q_SIZE{bus.a[Q_SIZE-1]}}, bus.a});
    prod_ext = {{LEN_WIDTH{prod[2*Q_SIZE-1]}}, prod};
    bias_ext = {{(ACC_W - Q_SIZE - Q_FRAC){bus.bias[Q_SIZE-1]}}, bus.bias, {Q_FRAC{1'b0}}};
    // Arithmetic shift of a two's-complement value rounds toward -infinity
    shifted  = acc_q >>> Q_FRAC;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = bias_ext;
          cnt_d    = bus.len;
          mask_d   = bus.mask_in;
          bypass_d = bus.bypass_in;
          state_d  = (bus.len != '0) ? ACCUM : FINISH;
        end
      end
      ACCUM: begin
        if (bus.in_valid && in_ready_q) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) state_d = FINISH;
        end
      end
      FINISH: begin
        if (shifted > SAT_MAX)      x_d = SAT_MAX[Q_SIZE-1:0];
        else if (shifted < SAT_MIN) x_d = SAT_MIN[Q_SIZE-1:0];
        else                        x_d = shifted[Q_SIZE-1:0];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status outputs are decoded from the next state so they are
    // plain flops aligned with the state register.
    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      mask_q      <= '0;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      mask_q      <= mask_d;
      bypass_q    <= bypass_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.mask       = mask_q;
  assign bus.act_bypass = bypass_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: jobs push expected results into a
// queue, a negedge monitor pops and compares on every out_valid&out_ready.
module tb_neuron_accumulator;
  localparam int Q_INT     = 8;
  localparam int Q_FRAC    = 8;
  localparam int MASK_W    = 4;
  localparam int LEN_WIDTH = 8;
  localparam int Q_SIZE    = Q_INT + Q_FRAC;

  typedef struct packed {
    logic [Q_SIZE-1:0] x;
    logic [MASK_W-1:0] m;
    logic              b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_accumulator_if #(.Q_SIZE(Q_SIZE), .LEN_WIDTH(LEN_WIDTH), .ACT_MASK_SIZE(MASK_W)) bus ();

  neuron_accumulator #(
    .Q_INT(Q_INT), .Q_FRAC(Q_FRAC), .ACT_MASK_SIZE(MASK_W), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] w_tab[0:7];
  logic [15:0] a_tab[0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: a result is consumed at the posedge following this sample
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got x=%h with no job outstanding", bus.x);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x", 32'(bus.x), 32'(e.x));
        check("mask", 32'(bus.mask), 32'(e.m));
        check("act_bypass", 32'(bus.act_bypass), 32'(e.b));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l, input logic [15:0] b, input logic [3:0] m, input logic byp);
    wait_idle();
    bus.start     = 1'b1;
    bus.len       = LEN_WIDTH'(l);
    bus.bias      = b;
    bus.mask_in   = m;
    bus.bypass_in = byp;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic feed(input int l, input bit gaps);
    for (int i = 0; i < l; i++) begin
      int n = 0;
      if (gaps) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.w        = w_tab[i];
      bus.a        = a_tab[i];
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Called just after the last beat (or a len=0 start): one FINISH cycle, then out_valid
  task automatic check_latency();
    @(negedge clk);
    check("finish_out_valid", 32'(bus.out_valid), 32'd0);
    check("finish_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("done_out_valid", 32'(bus.out_valid), 32'd1);
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic push(input logic [15:0] x, input logic [3:0] m, input logic b);
    exp_t e;
    e.x = x;
    e.m = m;
    e.b = b;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.start = 0; bus.len = '0; bus.bias = '0; bus.mask_in = '0; bus.bypass_in = 0;
    bus.in_valid = 0; bus.w = '0; bus.a = '0; bus.out_ready = 1'b1;

    #2;
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1.0 * 2.0
    w_tab[0] = 16'h0100; a_tab[0] = 16'h0200;
    push(16'h0200, 4'hA, 1'b1);
    start_job(1, 16'h0000, 4'hA, 1'b1);
    feed(1, 0);
    check_latency();

    // 0.5 + 1*1 + 2*0.5 + (-1)*0.25 = 2.25, streamed back-to-back and with gaps
    w_tab[0] = 16'h0100; a_tab[0] = 16'h0100;
    w_tab[1] = 16'h0200; a_tab[1] = 16'h0080;
    w_tab[2] = 16'hFF00; a_tab[2] = 16'h0040;
    push(16'h0240, 4'h5, 1'b0);
    start_job(3, 16'h0080, 4'h5, 1'b0);
    feed(3, 0);
    check_latency();
    push(16'h0240, 4'h6, 1'b1);
    start_job(3, 16'h0080, 4'h6, 1'b1);
    feed(3, 1);
    check_latency();

    // (-1/256) * 0.5 floors to -1/256
    w_tab[0] = 16'hFFFF; a_tab[0] = 16'h0080;
    push(16'hFFFF, 4'h1, 1'b0);
    start_job(1, 16'h0000, 4'h1, 1'b0);
    feed(1, 0);
    check_latency();

    // 4 * 10000 saturates high, 4 * -10000 saturates low
    for (int i = 0; i < 4; i++) begin w_tab[i] = 16'h6400; a_tab[i] = 16'h6400; end
    push(16'h7FFF, 4'h2, 1'b0);
    start_job(4, 16'h0000, 4'h2, 1'b0);
    feed(4, 0);
    check_latency();
    for (int i = 0; i < 4; i++) w_tab[i] = 16'h9C00;
    push(16'h8000, 4'h3, 1'b1);
    start_job(4, 16'h0000, 4'h3, 1'b1);
    feed(4, 0);
    check_latency();

    // len=0: result is the bias; a pair held on the bus must not be consumed
    bus.in_valid = 1'b1; bus.w = 16'h4000; bus.a = 16'h4000;
    push(16'hFE00, 4'h6, 1'b1);
    start_job(0, 16'hFE00, 4'h6, 1'b1);
    check_latency();
    wait_idle();
    bus.in_valid = 1'b0;

    // Backpressure: result held while out_ready=0, start pulses ignored
    bus.out_ready = 1'b0;
    w_tab[0] = 16'h0100; a_tab[0] = 16'h0100;
    push(16'h0200, 4'h3, 1'b1);
    start_job(1, 16'h0100, 4'h3, 1'b1);
    feed(1, 0);
    check_latency();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b1; bus.len = '0; bus.bias = 16'h7777; bus.mask_in = 4'hF; bus.bypass_in = 1'b0;
      @(negedge clk);
      check("hold_x", 32'(bus.x), 32'h0200);
      check("hold_mask", 32'(bus.mask), 32'h3);
      check("hold_bypass", 32'(bus.act_bypass), 32'h1);
      check("hold_out_valid", 32'(bus.out_valid), 32'h1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.bias = 16'h0300; bus.mask_in = 4'h7; bus.bypass_in = 1'b0;
    push(16'h0300, 4'h7, 1'b0);
    @(posedge clk); #1;
    check("accept_busy", 32'(bus.busy), 32'd0);
    check("accept_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    check_latency();
    wait_idle();

    // Reset mid-job: outputs clear at once, no result, next job uses fresh bias
    for (int i = 0; i < 5; i++) begin w_tab[i] = 16'h0100; a_tab[i] = 16'h0100; end
    start_job(5, 16'h0500, 4'h1, 1'b1);
    feed(2, 0);
    rst_n = 1'b0;
    #1;
    check("abort_x", 32'(bus.x), 32'd0);
    check("abort_mask", 32'(bus.mask), 32'd0);
    check("abort_bypass", 32'(bus.act_bypass), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(16'h0140, 4'h2, 1'b0);
    start_job(1, 16'h0040, 4'h2, 1'b0);
    feed(1, 0);
    check_latency();
    wait_idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
